// File: rtl/demux_scheduler_if.sv
// Handshake bundle between an upstream producer, the demux scheduler and
// four downstream channels (A..D). The master drives words in and accepts
// them on the far side; the slave is the scheduler.
interface demux_scheduler_if #(
  parameter int unsigned DW = 8
);

  // Upstream side
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_dest;
  logic          mode;

  // Downstream side, bit0=A .. bit3=D
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [DW-1:0] out_data;

  // Status
  logic [1:0]    sel;
  logic          busy;
  logic          stall;

  modport master (
    output in_valid,
    output in_data,
    output in_dest,
    output mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  sel,
    input  busy,
    input  stall
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_dest,
    input  mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output sel,
    output busy,
    output stall
  );

endinterface

// File: rtl/demux_scheduler.sv
// One-word demultiplexing scheduler. A word accepted from upstream is held
// and offered to exactly one of four channels, chosen either round-robin
// (mode=0) or by an explicit destination (mode=1). A held word that waits
// STALL_LIM cycles raises stall but is never dropped or rerouted.
// Optional feature: define DEMUX_SCHED_STATS_EN to add per-channel 8-bit
// delivery counters readable through stat_sel / stat_count.
module demux_scheduler #(
  parameter int unsigned DW        = 8,
  parameter int unsigned STALL_LIM = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  demux_scheduler_if.slave        bus
`ifdef DEMUX_SCHED_STATS_EN
  ,
  input  logic [1:0]              stat_sel,
  output logic [7:0]              stat_count
`endif
);

  localparam int unsigned NCH    = 4;
  localparam int unsigned SW     = 2;
  localparam int unsigned WCW    = (STALL_LIM < 1) ? 1 : $clog2(STALL_LIM + 1);
  localparam int unsigned STAT_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [DW-1:0]     data_q;
  logic [SW-1:0]     sel_q;
  logic [SW-1:0]     rr_q;
  logic [WCW-1:0]    wait_q;

  logic              xfer_in;
  logic              xfer_out;
  logic              in_ready_c;
  logic [SW-1:0]     cap_sel;

  // Handshake qualification: accept when empty or when the held word leaves now
  always_comb begin : handshake
    xfer_out   = (state_q == ST_SEND) && bus.out_ready[sel_q];
    in_ready_c = (state_q == ST_IDLE) || xfer_out;
    xfer_in    = bus.in_valid && in_ready_c;
    cap_sel    = bus.mode ? bus.in_dest : rr_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stay in SEND on simultaneous in/out transfers
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer_in) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer_out && !xfer_in) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Held word, its destination and the round-robin pointer update on capture only
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      sel_q  <= '0;
      rr_q   <= '0;
    end else if (xfer_in) begin
      data_q <= bus.in_data;
      sel_q  <= cap_sel;
      if (!bus.mode) begin
        rr_q <= rr_q + SW'(1);
      end
    end
  end

  // Wait counter: edges spent in SEND without delivery, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else if (xfer_out || (state_q == ST_IDLE)) begin
      wait_q <= '0;
    end else if (wait_q != WCW'(STALL_LIM)) begin
      wait_q <= wait_q + WCW'(1);
    end
  end

  // Output decode from registered state
  always_comb begin
    bus.out_valid = '0;
    if (state_q == ST_SEND) begin
      bus.out_valid[sel_q] = 1'b1;
    end
    bus.in_ready = in_ready_c;
    bus.out_data = data_q;
    bus.sel      = sel_q;
    bus.busy     = (state_q == ST_SEND);
    bus.stall    = (wait_q == WCW'(STALL_LIM));
  end

`ifdef DEMUX_SCHED_STATS_EN
  logic [STAT_W-1:0] stat_q [NCH];

  // Per-channel delivery counters, wrapping at 2^STAT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        stat_q[i] <= '0;
      end
    end else if (xfer_out) begin
      stat_q[sel_q] <= stat_q[sel_q] + STAT_W'(1);
    end
  end

  // Counter readback, combinational
  always_comb begin
    stat_count = stat_q[stat_sel];
  end
`endif

endmodule

// File: tb/tb_demux_scheduler.sv
// Self-checking bench for demux_scheduler: a transaction-level model of a
// one-word buffer plus a delivery scoreboard, compared on every negedge,
// together with directed scenarios that pin expected values by hand.
`timescale 1ns/1ps
module tb_demux_scheduler;

  localparam int unsigned DW        = 8;
  localparam int unsigned STALL_LIM = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux_scheduler_if #(.DW(DW)) bus ();

`ifdef DEMUX_SCHED_STATS_EN
  logic [1:0] stat_sel;
  logic [7:0] stat_count;
`endif

  demux_scheduler #(.DW(DW), .STALL_LIM(STALL_LIM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef DEMUX_SCHED_STATS_EN
    ,
    .stat_sel(stat_sel),
    .stat_count(stat_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] data;
  } xfer_t;

  bit            m_on = 1'b0;
  bit            m_held;
  int            m_sel, m_rr, m_wait;
  logic [DW-1:0] m_data;
  int            m_stat [4];
  xfer_t         exp_q [$];
  xfer_t         got_q [$];

  // A single-slot buffer: what leaves, what enters, where it goes
  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_held = 1'b0; m_sel = 0; m_rr = 0; m_wait = 0; m_data = '0;
      for (int i = 0; i < 4; i++) m_stat[i] = 0;
      exp_q.delete();
    end else if (m_on) begin
      bit    leaves, enters;
      int    dest;
      xfer_t t;
      leaves = m_held && bus.out_ready[m_sel];
      enters = bus.in_valid && (!m_held || leaves);
      if (leaves) begin
        m_stat[m_sel] = (m_stat[m_sel] + 1) % 256;
        m_held = 1'b0;
        m_wait = 0;
      end else if (m_held) begin
        m_wait = (m_wait + 1 > STALL_LIM) ? STALL_LIM : m_wait + 1;
      end
      if (enters) begin
        dest = bus.mode ? int'(bus.in_dest) : m_rr;
        if (!bus.mode) m_rr = (m_rr + 1) % 4;
        m_sel = dest; m_data = bus.in_data; m_held = 1'b1; m_wait = 0;
        t.ch = 2'(dest); t.data = bus.in_data;
        exp_q.push_back(t);
      end
    end
  end

  // Per-cycle comparison against the model, plus delivery scoreboard
  always @(negedge clk) begin : cmp
    logic [3:0] ev;
    xfer_t      g, e;
    if (m_on) begin
      ev = m_held ? 4'(1 << m_sel) : 4'b0000;
      check("in_ready",  32'(bus.in_ready),  32'(!m_held || bus.out_ready[m_sel]));
      check("out_valid", 32'(bus.out_valid), 32'(ev));
      check("out_data",  32'(bus.out_data),  32'(m_data));
      check("sel",       32'(bus.sel),       32'(m_sel));
      check("busy",      32'(bus.busy),      32'(m_held));
      check("stall",     32'(bus.stall),     32'(m_wait >= STALL_LIM));
`ifdef DEMUX_SCHED_STATS_EN
      check("stat_count", 32'(stat_count), 32'(m_stat[stat_sel]));
`endif
      if (!rst && ((bus.out_valid & bus.out_ready) != 4'b0000)) begin
        g.ch = bus.sel; g.data = bus.out_data;
        got_q.push_back(g);
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL delivery: got ch %0d data 0x%0h, required no delivery", g.ch, g.data);
        end else begin
          e = exp_q.pop_front();
          if (e === g) n_pass++;
          else $display("FAIL delivery: got ch %0d data 0x%0h required ch %0d data 0x%0h",
                        g.ch, g.data, e.ch, e.data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit md,
                       input logic [1:0] dst, input logic [3:0] rdy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.mode      = md;
    bus.in_dest   = dst;
    bus.out_ready = rdy;
  endtask

  int base;

  initial begin
    drive(0, 8'h00, 0, 2'd0, 4'h0);
`ifdef DEMUX_SCHED_STATS_EN
    stat_sel = 2'd2;
`endif
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_busy",      32'(bus.busy),      32'h0);
    check("rst_stall",     32'(bus.stall),     32'h0);
    check("rst_sel",       32'(bus.sel),       32'h0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    check("rst_in_ready",  32'(bus.in_ready),  32'h1);

    // Round-robin burst, all channels ready
    base = got_q.size();
    drive(1, 8'h11, 0, 2'd3, 4'hF); tick();
    check("rr_a_valid", 32'(bus.out_valid), 32'h1);
    check("rr_a_data",  32'(bus.out_data),  32'h11);
    drive(1, 8'h22, 0, 2'd3, 4'hF); tick();
    check("rr_b_valid", 32'(bus.out_valid), 32'h2);
    drive(1, 8'h33, 0, 2'd3, 4'hF); tick();
    check("rr_c_valid", 32'(bus.out_valid), 32'h4);
    drive(1, 8'h44, 0, 2'd3, 4'hF); tick();
    check("rr_d_valid", 32'(bus.out_valid), 32'h8);
    check("rr_d_data",  32'(bus.out_data),  32'h44);
    drive(0, 8'h00, 0, 2'd0, 4'hF); tick();
    check("rr_idle_busy", 32'(bus.busy), 32'h0);
    check("rr_count", 32'(got_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() > base + i) begin
        check("rr_order_ch",   32'(got_q[base + i].ch),   32'(i));
        check("rr_order_data", 32'(got_q[base + i].data), 32'(8'h11 * (i + 1)));
      end
    end

    // Pointer wrapped to A; non-selected ready lines are ignored
    drive(1, 8'h55, 0, 2'd3, 4'h0); tick();
    check("wrap_sel",   32'(bus.sel),       32'h0);
    check("wrap_valid", 32'(bus.out_valid), 32'h1);
    drive(0, 8'h00, 0, 2'd0, 4'b1110); tick();
    check("ignore_busy", 32'(bus.busy),     32'h1);
    check("ignore_data", 32'(bus.out_data), 32'h55);
    drive(0, 8'h00, 0, 2'd0, 4'b0001); tick();
    check("ignore_done", 32'(bus.busy), 32'h0);

    // Explicit destination C
    drive(1, 8'hA5, 1, 2'd2, 4'b0100); tick();
    check("exp_valid", 32'(bus.out_valid), 32'h4);
    check("exp_data",  32'(bus.out_data),  32'hA5);
    drive(0, 8'hA5, 1, 2'd2, 4'b0100); tick();
    check("exp_busy", 32'(bus.busy), 32'h0);

    // Stall on D while other channels are ready
    drive(1, 8'h3C, 1, 2'd3, 4'b0111); tick();
    drive(1, 8'h99, 0, 2'd0, 4'b0111);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 15) check("stall_before", 32'(bus.stall), 32'h0);
      if (k == 16) check("stall_at_lim", 32'(bus.stall), 32'h1);
      if (k == 16) check("stall_in_ready", 32'(bus.in_ready), 32'h0);
      if (k == 20) check("stall_held", 32'(bus.stall), 32'h1);
    end
    drive(0, 8'h99, 0, 2'd0, 4'b1111); #1;
    check("stall_release_ready", 32'(bus.in_ready), 32'h1);
    tick();
    check("stall_clear", 32'(bus.stall),    32'h0);
    check("stall_idle",  32'(bus.busy),     32'h0);
    check("stall_data",  32'(bus.out_data), 32'h3C);

    // Reset while a word for B is held
    drive(1, 8'h77, 0, 2'd0, 4'h0); tick();
    check("pre_rst_sel", 32'(bus.sel), 32'h1);
    rst = 1'b1;
    drive(1, 8'h88, 0, 2'd0, 4'h0); tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_busy",  32'(bus.busy),      32'h0);
    check("mid_rst_sel",   32'(bus.sel),       32'h0);
    drive(1, 8'h66, 0, 2'd0, 4'h0); tick();
    check("post_rst_sel",   32'(bus.sel),       32'h0);
    check("post_rst_data",  32'(bus.out_data),  32'h66);
    drive(0, 8'h00, 0, 2'd0, 4'b0001); tick();

    // mode/in_dest changes after capture do not affect held word or pointer
    drive(1, 8'h5A, 1, 2'd1, 4'h0); tick();
    drive(0, 8'h00, 0, 2'd3, 4'h0); tick(); tick();
    check("hold_sel",  32'(bus.sel),      32'h1);
    check("hold_data", 32'(bus.out_data), 32'h5A);
    drive(0, 8'h00, 0, 2'd3, 4'b0010); tick();
    drive(1, 8'hC3, 0, 2'd0, 4'h0); tick();
    check("rr_not_advanced", 32'(bus.sel), 32'h1);
    drive(0, 8'h00, 0, 2'd0, 4'b0010); tick();

    // Mixed back-to-back traffic checked by the model
    drive(1, 8'h01, 0, 2'd0, 4'hF); tick();
    drive(1, 8'h02, 1, 2'd0, 4'h8); tick();
    drive(1, 8'h03, 1, 2'd1, 4'h1); tick();
    drive(1, 8'h04, 0, 2'd2, 4'h0); tick();
    drive(1, 8'h05, 0, 2'd2, 4'h2); tick();
    drive(0, 8'h06, 1, 2'd3, 4'hF); tick();
    drive(1, 8'h07, 1, 2'd3, 4'h7); tick();
    drive(1, 8'h08, 0, 2'd0, 4'hF); tick();
    drive(1, 8'h09, 0, 2'd0, 4'hF); tick();
    drive(0, 8'h00, 0, 2'd0, 4'hF); tick(); tick();

`ifdef DEMUX_SCHED_STATS_EN
    // 257 deliveries to C wrap its counter to 1
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1, 8'h00, 1, 2'd2, 4'b0100);
    for (int i = 0; i < 257; i++) begin
      bus.in_data = 8'(i);
      tick();
    end
    drive(0, 8'h00, 1, 2'd2, 4'b0100); tick();
    stat_sel = 2'd2; #1;
    check("stat_c_wrap", 32'(stat_count), 32'd1);
    for (int c = 0; c < 4; c++) begin
      if (c != 2) begin
        stat_sel = 2'(c); #1;
        check("stat_other", 32'(stat_count), 32'd0);
      end
    end
    stat_sel = 2'd2;
`endif

    drive(0, 8'h00, 0, 2'd0, 4'hF); tick(); tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_scheduler.md
DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 Parameter: DW, default 8, width of the routed data word.
REQ-002 Parameter: STALL_LIM, default 16, wait cycles in SEND before stall asserts.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream word available.
REQ-006 in_ready  output  1  scheduler accepts word this cycle.
REQ-007 in_data  input  DW  upstream word.
REQ-008 in_dest  input  2  explicit destination 0..3 (A..D), used when mode=1.
REQ-009 mode  input  1  0 = round-robin destination, 1 = explicit destination.
REQ-010 out_valid  output  4  one-hot per-channel valid; bit0=A, bit1=B, bit2=C, bit3=D.
REQ-011 out_ready  input  4  per-channel ready, same bit order.
REQ-012 out_data  output  DW  held word, shared by all channels.
REQ-013 sel  output  2  destination of the held word.
REQ-014 busy  output  1  high while a word is held.
REQ-015 stall  output  1  held word waiting STALL_LIM or more cycles.

Function
REQ-016 FSM states: IDLE (no word held), SEND (word held, out_valid[sel] high).
REQ-017 in_ready = (state==IDLE) or (state==SEND and out_ready[sel]); combinational.
REQ-018 Transfer in: in_valid and in_ready at an edge -> capture in_data into out_data; sel = in_dest if mode=1, else rr_ptr; state -> SEND.
REQ-019 mode and in_dest sampled only at capture; later changes do not affect the held word.
REQ-020 In SEND, out_valid is exactly one-hot at bit sel; all other bits 0; in IDLE out_valid = 0.
REQ-021 Transfer out: out_valid[sel] and out_ready[sel] at an edge; out_ready of non-selected channels ignored.
REQ-022 Transfer out without simultaneous transfer in -> state IDLE, out_data holds its last value.
REQ-023 Simultaneous transfer out and transfer in -> state stays SEND with the new word and sel; back-to-back throughput of one word per cycle.
REQ-024 Latency: word captured at edge N is presented on out_valid/out_data from edge N to the next transfer out; no combinational path from in_data to out_data.
REQ-025 rr_ptr (2 bits) advances by 1 on every capture made with mode=0; wraps 3 -> 0; unchanged on mode=1 captures.
REQ-026 busy = (state==SEND).
REQ-027 Wait counter counts edges in SEND without transfer out; saturates at STALL_LIM; clears on transfer out.
REQ-028 stall = (wait counter == STALL_LIM); no word is dropped or rerouted on stall.

Reset
REQ-029 rst high at an edge: state=IDLE, rr_ptr=0, sel=0, out_data=0, wait counter=0, and statistics counters=0 when compiled in.
REQ-030 Reset outputs: out_valid=0, busy=0, stall=0; in_ready=1 on the first cycle after reset.
REQ-031 Reset in SEND discards the held word; in_valid during a reset cycle is not captured.

Configuration
REQ-032 Macro DEMUX_SCHED_STATS_EN defined: extra ports stat_sel (input, 2) and stat_count (output, 8).
REQ-033 With the macro: four 8-bit counters, one per channel, +1 on each transfer out to that channel, wrap 255 -> 0; stat_count = counter[stat_sel], combinational.
REQ-034 Without the macro: no stat ports, no counters; all other behaviour identical.

Verification
REQ-035 Reset, mode=0, four words 0x11,0x22,0x33,0x44 with all out_ready=1 -> delivered to A,B,C,D in order, one per cycle; rr_ptr back to 0.
REQ-036 mode=1, in_dest=2, in_data=0xA5, out_ready=0100 -> out_valid=0100, out_data=0xA5, one cycle later busy=0.
REQ-037 mode=1, in_dest=3, out_ready=0111 for 20 cycles -> in_ready=0, stall=1 from the 16th wait cycle; out_ready[3]=1 -> word delivered, stall=0.
REQ-038 Word held for B, rst pulsed for one cycle -> out_valid=0000, busy=0, sel=0, next mode=0 word goes to A.
REQ-039 mode=1 word held, mode toggled to 0 and in_dest changed before delivery -> sel unchanged; rr_ptr not advanced.
REQ-040 With DEMUX_SCHED_STATS_EN: 257 words to C -> stat_sel=2 reads 1; other counters 0.
